// File: rtl/s2p_pkg.sv
// Shared constants and types for the s2p family of serial-to-parallel deserialisers.
package s2p_pkg;

  localparam logic ORDER_MSB = 1'b1;
  localparam logic ORDER_LSB = 1'b0;

  localparam int S2P_WIDTH = 10;
  localparam int S2P_LANES = 1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // A single-beat word still needs a one-bit counter so the port never collapses to zero width.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// Valid/ready holding register for assembled words, with a sticky overflow flag
// raised whenever a new word arrives while the held one is still unconsumed.
module s2p_out_reg
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             rdy_i,
  input  logic             ovfClr_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             vld_o,
  output logic             ovf_o
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  // Clear is applied first so that a simultaneous overflow wins.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q & ~ovfClr_i;
    case (state_q)
      OUT_EMPTY: begin
        if (load_i) begin
          state_d = OUT_FULL;
          data_d  = word_i;
        end
      end
      OUT_FULL: begin
        if (load_i) begin
          if (rdy_i) begin
            data_d = word_i;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (rdy_i) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  assign dout_o = data_q;
  assign vld_o  = (state_q == OUT_FULL);
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/s2p_frame.sv
// Parametrised deserialiser: LANES bits per beat into WIDTH-bit words, selectable bit order,
// start-of-frame realignment and a holding register that reports dropped words via ovf.
module s2p_frame
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH,
  parameter int LANES = S2P_LANES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] din,
  input  logic             din_vld,
  input  logic             sof,
  input  logic             msb_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic             align_err
);

  localparam int             BEATS = WIDTH / LANES;
  localparam int             CW    = cnt_width(BEATS);
  localparam logic [CW-1:0]  LAST  = CW'(BEATS - 1);

  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             order_q, order_d;
  logic             alignErr_q, alignErr_d;

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] msbShift;
  logic [WIDTH-1:0] lsbShift;
  logic [CW-1:0]    beatIdx;
  logic             complete;

  // A sof beat is treated as beat 0 of an empty word, so leftovers never leak in.
  assign base    = sof ? '0 : shiftReg_q;
  assign beatIdx = sof ? '0 : cnt_q;

  generate
    if (BEATS == 1) begin : g_single
      assign msbShift = din;
      assign lsbShift = din;
    end else begin : g_multi
      assign msbShift = {base[WIDTH-LANES-1:0], din};
      assign lsbShift = {din, base[WIDTH-1:LANES]};
    end
  endgenerate

  always_comb begin
    shiftReg_d = shiftReg_q;
    cnt_d      = cnt_q;
    order_d    = order_q;
    alignErr_d = din_vld && sof && (cnt_q != '0);
    complete   = 1'b0;
    if (din_vld) begin
      if (beatIdx == '0) begin
        order_d = msb_first;
      end
      shiftReg_d = (order_d == ORDER_MSB) ? msbShift : lsbShift;
      complete   = (beatIdx == LAST);
      cnt_d      = complete ? '0 : beatIdx + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg_q <= '0;
      cnt_q      <= '0;
      order_q    <= ORDER_LSB;
      alignErr_q <= 1'b0;
    end else begin
      shiftReg_q <= shiftReg_d;
      cnt_q      <= cnt_d;
      order_q    <= order_d;
      alignErr_q <= alignErr_d;
    end
  end

  assign align_err = alignErr_q;

  s2p_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (complete),
    .word_i  (shiftReg_d),
    .rdy_i   (dout_rdy),
    .ovfClr_i(ovf_clr),
    .dout_o  (dout),
    .vld_o   (dout_vld),
    .ovf_o   (ovf)
  );

endmodule

// File: tb/tb_s2p_frame.sv
// Scoreboard bench for s2p_frame: a 10x1 instance and an 8x2 instance share clock and reset.
module tb_s2p_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [0:0] din10;
  logic       vld10, sof10, msb10, rdy10, clr10;
  logic [9:0] dout10;
  logic       dv10, ovf10, ae10;

  logic [1:0] din8;
  logic       vld8, sof8, msb8, rdy8, clr8;
  logic [7:0] dout8;
  logic       dv8, ovf8, ae8;

  s2p_frame #(.WIDTH(10), .LANES(1)) dut10 (
    .clk(clk), .rst_n(rst_n), .din(din10), .din_vld(vld10), .sof(sof10),
    .msb_first(msb10), .dout(dout10), .dout_vld(dv10), .dout_rdy(rdy10),
    .ovf(ovf10), .ovf_clr(clr10), .align_err(ae10)
  );

  s2p_frame #(.WIDTH(8), .LANES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .din_vld(vld8), .sof(sof8),
    .msb_first(msb8), .dout(dout8), .dout_vld(dv8), .dout_rdy(rdy8),
    .ovf(ovf8), .ovf_clr(clr8), .align_err(ae8)
  );

  logic [9:0] exp10[$];
  logic [7:0] exp8[$];
  int testsRun    = 0;
  int testsFailed = 0;
  int hs10        = 0;
  int aeCount10   = 0;
  int aeCount8    = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word is popped from the matching queue and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ae10) aeCount10++;
        if (ae8) aeCount8++;
        if (dv10 && rdy10) begin
          hs10++;
          if (exp10.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL dout10_unexpected: got %0h, expected no word", dout10);
          end else begin
            checkOutput("dout10", {22'd0, dout10}, {22'd0, exp10.pop_front()});
          end
        end
        if (dv8 && rdy8) begin
          if (exp8.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL dout8_unexpected: got %0h, expected no word", dout8);
          end else begin
            checkOutput("dout8", {24'd0, dout8}, {24'd0, exp8.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // seq[9] is the first bit on the wire; flipMid toggles msb_first after the first beat.
  task automatic applyStimulus10(input logic [9:0] seq, input logic msb, input logic sofFirst,
                                 input int gap, input logic flipMid, input logic clrLast);
    for (int i = 0; i < 10; i++) begin
      din10 = seq[9-i];
      vld10 = 1'b1;
      sof10 = sofFirst && (i == 0);
      msb10 = (i == 0 || !flipMid) ? msb : ~msb;
      clr10 = clrLast && (i == 9);
      tick();
      vld10 = 1'b0;
      sof10 = 1'b0;
      clr10 = 1'b0;
      if (i == 1 || i == 6) begin
        for (int g = 0; g < gap; g++) tick();
      end
    end
  endtask

  task automatic sendRaw10(input logic b);
    din10 = b;
    vld10 = 1'b1;
    tick();
    vld10 = 1'b0;
  endtask

  task automatic applyStimulus8(input logic [7:0] seq, input logic msb);
    for (int i = 0; i < 4; i++) begin
      din8 = seq[7-2*i -: 2];
      vld8 = 1'b1;
      sof8 = (i == 0);
      msb8 = msb;
      tick();
      vld8 = 1'b0;
      sof8 = 1'b0;
    end
  endtask

  int aeBefore;
  int hsBefore;

  initial begin
    rst_n = 1'b0;
    din10 = '0; vld10 = 0; sof10 = 0; msb10 = 0; rdy10 = 1; clr10 = 0;
    din8  = '0; vld8  = 0; sof8  = 0; msb8  = 0; rdy8  = 1; clr8  = 0;
    tick();
    tick();
    checkOutput("reset_dout", {22'd0, dout10}, 32'h0);
    checkOutput("reset_vld", {31'd0, dv10}, 32'h0);
    checkOutput("reset_ovf", {31'd0, ovf10}, 32'h0);
    checkOutput("reset_align", {31'd0, ae10}, 32'h0);
    rst_n = 1'b1;
    tick();

    exp10.push_back(10'h2CB);
    applyStimulus10(10'b1011001011, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    checkOutput("msb_vld_high", {31'd0, dv10}, 32'h1);
    tick();
    checkOutput("msb_vld_pulse", {31'd0, dv10}, 32'h0);

    exp10.push_back(10'h34D);
    applyStimulus10(10'b1011001011, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    exp10.push_back(10'h34D);
    applyStimulus10(10'b1011001011, 1'b0, 1'b1, 3, 1'b1, 1'b0);
    tick();
    checkOutput("sof_at_zero_silent", aeCount10, 32'd0);

    rdy10 = 1'b0;
    exp10.push_back(10'h3C3);
    applyStimulus10(10'b1111000011, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus10(10'b0000011111, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    checkOutput("ovf_dout_held", {22'd0, dout10}, 32'h3C3);
    checkOutput("ovf_vld_held", {31'd0, dv10}, 32'h1);
    checkOutput("ovf_set", {31'd0, ovf10}, 32'h1);
    rdy10 = 1'b1;
    tick();
    checkOutput("drain_vld_low", {31'd0, dv10}, 32'h0);
    checkOutput("ovf_sticky", {31'd0, ovf10}, 32'h1);
    clr10 = 1'b1;
    tick();
    clr10 = 1'b0;
    checkOutput("ovf_cleared", {31'd0, ovf10}, 32'h0);
    rdy10 = 1'b0;
    exp10.push_back(10'h2AA);
    applyStimulus10(10'b1010101010, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus10(10'b0101010101, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    checkOutput("ovf_set_beats_clr", {31'd0, ovf10}, 32'h1);
    checkOutput("ovf2_dout_held", {22'd0, dout10}, 32'h2AA);
    rdy10 = 1'b1;
    tick();
    checkOutput("drain2_vld_low", {31'd0, dv10}, 32'h0);

    aeBefore = aeCount10;
    for (int i = 0; i < 4; i++) sendRaw10(1'b1);
    exp10.push_back(10'h333);
    applyStimulus10(10'b1100110011, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    tick();
    checkOutput("align_err_once", aeCount10 - aeBefore, 32'd1);

    exp8.push_back(8'hB1);
    applyStimulus8(8'b10110001, 1'b1);
    checkOutput("lanes2_vld", {31'd0, dv8}, 32'h1);
    exp8.push_back(8'h4E);
    applyStimulus8(8'b10110001, 1'b0);
    tick();

    rdy10 = 1'b0;
    applyStimulus10(10'b1000000001, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    checkOutput("pre_reset_vld", {31'd0, dv10}, 32'h1);
    for (int i = 0; i < 5; i++) sendRaw10(1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_dout", {22'd0, dout10}, 32'h0);
    checkOutput("async_reset_vld", {31'd0, dv10}, 32'h0);
    checkOutput("async_reset_ovf", {31'd0, ovf10}, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    rdy10 = 1'b1;
    hsBefore = hs10;
    exp10.push_back(10'h2CB);
    applyStimulus10(10'b1011001011, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("post_reset_once", hs10 - hsBefore, 32'd1);

    tick();
    checkOutput("queue10_empty", exp10.size(), 32'd0);
    checkOutput("queue8_empty", exp8.size(), 32'd0);
    checkOutput("lanes2_no_ovf", {31'd0, ovf8}, 32'h0);
    checkOutput("lanes2_no_align", aeCount8, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/s2p_frame.md
Name: s2p_frame

Overview:
Parametrised serial-to-parallel deserialiser and successor to the fixed 10-bit s2p. It accepts LANES bits per valid beat, assembles WIDTH-bit words in either bit order, realigns on a start-of-frame strobe, and presents words through a valid/ready holding register. It detects overflow and misalignment, and sits between a serial link front-end and word-level consumers.

Parameters:
WIDTH, 10, output word width in bits; must satisfy WIDTH % LANES == 0.
LANES, 1, serial bits accepted per valid beat; 1 <= LANES <= WIDTH.
BEATS (localparam), WIDTH/LANES, beats per word.
CW (localparam), max(1, clog2(BEATS)), beat counter width.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
din  in  LANES  serial lane data, sampled when din_vld=1.
din_vld  in  1  beat qualifier; when low, state holds (gaps allowed anywhere).
sof  in  1  start-of-frame; honoured only when din_vld=1.
msb_first  in  1  bit order; 1 = first-received bit is the word MSB.
dout  out  WIDTH  assembled word.
dout_vld  out  1  dout holds an unconsumed word.
dout_rdy  in  1  consumer accepts when dout_vld && dout_rdy.
ovf  out  1  sticky overflow flag.
ovf_clr  in  1  synchronous clear for ovf.
align_err  out  1  one-cycle pulse on a mid-word sof.

Behaviour:
- Reset, asynchronous: shift register, beat counter, dout, dout_vld, ovf and align_err all clear to 0; the latched order bit clears to 0.
- Assembly, per valid beat:
  - When the beat counter is 0, or sof=1, latch msb_first. Changing msb_first mid-word has no effect on the current word.
  - MSB-first: sr <= {sr[WIDTH-LANES-1:0], din}; din[LANES-1] is the earlier bit.
  - LSB-first: sr <= {din, sr[WIDTH-1:LANES]}; din[0] is the earlier bit. The first beat lands in dout[LANES-1:0].
  - The counter increments and wraps from BEATS-1 to 0. With BEATS=1, every valid beat completes a word.
- sof with din_vld:
  - The current beat becomes beat 0 of a new word and the counter becomes 1 (or 0 if BEATS=1).
  - Any partial word is discarded.
  - If the counter was nonzero, align_err pulses for 1 cycle.
  - sof at counter 0 is silent.
- Completion: the edge that samples the last beat forms the word {sr shifted with din}. That word appears on dout with dout_vld=1 after the same edge, i.e. 0 cycles after the last beat is sampled.
- Output register, states EMPTY (dout_vld=0) and FULL (dout_vld=1):
  - EMPTY + completion -> FULL, load word.
  - FULL + dout_rdy + no completion -> EMPTY; dout retains its last value.
  - FULL + dout_rdy + completion -> FULL, load new word (back-to-back, no bubble).
  - FULL + !dout_rdy + completion -> FULL, new word dropped, old dout kept, ovf set.
- ovf is sticky until ovf_clr. If set and clear occur in the same cycle, set wins.
- Reset mid-word discards the partial word; the next valid beat is beat 0.
- The counter is unaffected by dout_rdy; the input never stalls, and loss is reported only via ovf.

Decomposition:
- Shared package s2p_pkg:
  - Order encodings ORDER_MSB=1'b1, ORDER_LSB=1'b0.
  - Counter-width helper function.
  - Default WIDTH/LANES constants, so s2p and s2p_frame share values.
- Sub-module s2p_out_reg: WIDTH-bit valid/ready holding register with overflow flag and ovf_clr. The top level holds the shift register, counter, order latch and sof/align logic.

Test Plan:
- WIDTH=10, LANES=1, msb_first=1, dout_rdy=1, sof on first bit, bits 1,0,1,1,0,0,1,0,1,1 -> dout=10'h2CB, one-cycle dout_vld, align_err=0.
- Same bits with msb_first=0; then the same bits with din_vld dropped for 3 cycles after bits 2 and 7 -> both words give dout=10'h34D; the gaps do not change the result.
- dout_rdy=0, send two full words -> first word held on dout, dout_vld=1, ovf=1. Then dout_rdy=1 -> dout_vld falls. Then ovf_clr together with a third overflow -> ovf stays 1.
- Send 4 bits, then sof with the next beat -> align_err pulses once; the following 10 bits (sof on the first) form a word with the correct value, and the 4 stray bits are absent.
- WIDTH=8, LANES=2, msb_first=1, beats 2'b10, 2'b11, 2'b00, 2'b01 -> dout=8'hB1. Then msb_first=0 with the same beats -> dout=8'h4E.
- Reset asserted after 5 of 10 bits -> dout_vld=0, ovf=0, dout=0 immediately (asynchronously). After release, 10 clean bits produce the correct word exactly once.
